// File: rtl/rr_line_encoder_pkg.sv
// Shared constants and output field layout for the round-robin line encoder.
// io_in carries clock, reset and request lines; io_out is one packed register.
package rr_line_encoder_pkg;

    localparam int NUM_LINES = 6;
    localparam int CODE_W    = 3;
    localparam int COUNT_W   = 3;

    // io_in bit positions
    localparam int CLK_BIT = 0;
    localparam int RST_BIT = 1;
    localparam int REQ_LSB = 2;

    // io_out bit positions
    localparam int CODE_LSB  = 0;
    localparam int VALID_BIT = 3;
    localparam int MULTI_BIT = 4;
    localparam int COUNT_LSB = 5;

    typedef struct packed {
        logic [COUNT_W-1:0] count;
        logic               multi;
        logic               valid;
        logic [CODE_W-1:0]  code;
    } out_fields_t;

endpackage

// File: rtl/rr_line_encoder_rr_pick.sv
// Combinational round-robin picker: first set pending bit at or after ptr,
// wrapping from the last line back to line 0.
module rr_pick #(
    parameter int NUM_LINES = rr_line_encoder_pkg::NUM_LINES,
    parameter int CODE_W    = rr_line_encoder_pkg::CODE_W
) (
    input  logic [NUM_LINES-1:0] pending,
    input  logic [CODE_W-1:0]    ptr,
    output logic                 found,
    output logic [CODE_W-1:0]    index,
    output logic [NUM_LINES-1:0] onehot
);

    always_comb begin
        int idx;
        found  = 1'b0;
        index  = '0;
        onehot = '0;
        idx    = 0;
        for (int k = 0; k < NUM_LINES; k++) begin
            idx = (int'(ptr) + k) % NUM_LINES;
            if (!found && pending[idx]) begin
                found       = 1'b1;
                index       = CODE_W'(idx);
                onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_line_encoder.sv
// Edge-detecting round-robin encoder: each 0->1 request edge is queued and
// later reported once as its line number, one event per clock.
module rr_line_encoder #(
    parameter int NUM_LINES = rr_line_encoder_pkg::NUM_LINES,
    parameter int CODE_W    = rr_line_encoder_pkg::CODE_W
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    import rr_line_encoder_pkg::*;

    logic                 clk;
    logic                 rst;
    logic [NUM_LINES-1:0] req_q;
    logic [NUM_LINES-1:0] req_prev;
    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] pending;
    logic [NUM_LINES-1:0] onehot;
    logic [NUM_LINES-1:0] grant_onehot;
    logic [CODE_W-1:0]    ptr;
    logic [CODE_W-1:0]    index;
    logic                 found;
    logic [COUNT_W-1:0]   pend_cnt;
    out_fields_t          out_p2;

    function automatic logic [COUNT_W-1:0] popcount(input logic [NUM_LINES-1:0] v);
        logic [COUNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_LINES; i++) begin
            c = c + COUNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [CODE_W-1:0] next_ptr(input logic [CODE_W-1:0] idx);
        return (idx == CODE_W'(NUM_LINES - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign clk          = io_in[CLK_BIT];
    assign rst          = io_in[RST_BIT];
    assign rise         = req_q & ~req_prev;
    assign grant_onehot = found ? onehot : '0;
    assign pend_cnt     = popcount(pending);

    rr_pick #(
        .NUM_LINES (NUM_LINES),
        .CODE_W    (CODE_W)
    ) u_rr_pick (
        .pending (pending),
        .ptr     (ptr),
        .found   (found),
        .index   (index),
        .onehot  (onehot)
    );

    // Stage p0/p1: request sampling and edge history; pending queue; p2: output register
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q    <= '0;
            req_prev <= '0;
            pending  <= '0;
            ptr      <= '0;
            out_p2   <= '0;
        end else begin
            req_q    <= io_in[REQ_LSB +: NUM_LINES];
            req_prev <= req_q;
            // A fresh rise on the granted bit wins over its clear, so no event is lost
            pending  <= (pending & ~grant_onehot) | rise;
            if (found) begin
                ptr          <= next_ptr(index);
                out_p2.code  <= index;
                out_p2.valid <= 1'b1;
                out_p2.multi <= (pend_cnt > COUNT_W'(1));
                out_p2.count <= pend_cnt;
            end else begin
                out_p2 <= '0;
            end
        end
    end

    assign io_out = out_p2;

endmodule

// File: tb/tb_rr_line_encoder.sv
// Directed bench for rr_line_encoder: expected io_out bytes are queued with the
// cycle they are due and checked just after each rising edge.
module tb_rr_line_encoder;

    logic       clk;
    logic       rst;
    logic [5:0] lines;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int         due;
        logic [7:0] val;
        string      tag;
    } exp_t;

    exp_t sb[$];

    assign io_in = {lines, rst, clk};

    rr_line_encoder dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] enc(input int code, input bit valid, input bit multi, input int count);
        logic [2:0] c3;
        logic [2:0] n3;
        c3 = code[2:0];
        n3 = count[2:0];
        return {n3, multi, valid, c3};
    endfunction

    task automatic expect_at(input int delta, input logic [7:0] v, input string tag);
        exp_t e;
        e.due = cyc + delta;
        e.val = v;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic expect_idle(input int from, input int to, input string tag);
        for (int d = from; d <= to; d++) expect_at(d, 8'h00, tag);
    endtask

    task automatic tick();
        int i;
        @(posedge clk);
        cyc++;
        #1;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                n_tests++;
                assert (io_out === sb[i].val) else begin
                    n_fail++;
                    $error("FAIL %s @cycle %0d: io_out=%02h expected %02h", sb[i].tag, cyc, io_out, sb[i].val);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst   = 1'b1;
        lines = 6'b0;
        expect_idle(1, 2, "reset");
        ticks(2);
        rst = 1'b0;
        ticks(2);

        // Single L2 pulse held 3 cycles: one 0x2A three edges after first sample
        lines = 6'b000100;
        expect_idle(1, 2, "l2_latency");
        expect_at(3, 8'h2A, "l2_grant");
        expect_idle(4, 6, "l2_after");
        ticks(3);
        lines = 6'b0;
        ticks(3);

        // Reset to bring ptr back to 0
        rst = 1'b1;
        expect_at(1, 8'h00, "reset_mid_idle");
        tick();
        rst = 1'b0;
        ticks(2);

        // L0, L3, L5 together from ptr 0
        lines = 6'b101001;
        expect_at(3, enc(0, 1, 1, 3), "triple_code0");
        expect_at(4, enc(3, 1, 1, 2), "triple_code3");
        expect_at(5, enc(5, 1, 0, 1), "triple_code5");
        expect_idle(6, 7, "triple_after");
        ticks(2);
        lines = 6'b0;
        ticks(5);

        // L1, L4 together: L1 first only if ptr wrapped back to 0; leaves ptr at 5
        lines = 6'b010010;
        expect_at(3, enc(1, 1, 1, 2), "ptr0_code1");
        expect_at(4, enc(4, 1, 0, 1), "ptr0_code4");
        expect_at(5, 8'h00, "ptr0_after");
        tick();
        lines = 6'b0;
        ticks(5);

        // Wrap: ptr 5, L1 and L5 together -> L5 then L1, ptr ends at 2
        lines = 6'b100010;
        expect_at(3, enc(5, 1, 1, 2), "wrap_code5");
        expect_at(4, enc(1, 1, 0, 1), "wrap_code1");
        expect_at(5, 8'h00, "wrap_after");
        tick();
        lines = 6'b0;
        ticks(5);

        // Re-rise: L2 (granted first from ptr 2) delays L1, whose second rise
        // lands on the cycle L1 is granted
        lines = 6'b000110;
        expect_at(3, enc(2, 1, 1, 2), "rerise_code2");
        expect_at(4, enc(1, 1, 0, 1), "rerise_code1_a");
        expect_at(5, enc(1, 1, 0, 1), "rerise_code1_b");
        expect_idle(6, 7, "rerise_after");
        tick();
        lines = 6'b000100;
        tick();
        lines = 6'b000110;
        ticks(2);
        lines = 6'b0;
        ticks(5);

        // Reset with four events pending: everything discarded
        lines = 6'b011011;
        expect_idle(1, 8, "rst_discard");
        ticks(2);
        rst   = 1'b1;
        lines = 6'b0;
        tick();
        rst = 1'b0;
        ticks(5);

        // New rises after that reset start again from ptr 0
        lines = 6'b010100;
        expect_at(3, enc(2, 1, 1, 2), "post_rst_code2");
        expect_at(4, enc(4, 1, 0, 1), "post_rst_code4");
        expect_at(5, 8'h00, "post_rst_after");
        tick();
        lines = 6'b0;
        ticks(5);

        // All six lines held high through reset release: one event each, in order
        rst   = 1'b1;
        lines = 6'b111111;
        expect_idle(1, 2, "all_in_reset");
        ticks(2);
        rst = 1'b0;
        expect_idle(1, 2, "all_latency");
        for (int i = 0; i < 6; i++) begin
            expect_at(3 + i, enc(i, 1, (i < 5), 6 - i), $sformatf("all_code%0d", i));
        end
        expect_idle(9, 14, "all_held_idle");
        ticks(15);
        lines = 6'b0;
        ticks(2);

        while (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s: never checked, due cycle %0d expected %02h", sb[0].tag, sb[0].due, sb[0].val);
            sb.delete(0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
